// File: rtl/axi4_mem_slave_if.sv
`default_nettype none
// ==========================================================================
// AXI4_iface: AXI4 channel bundle, with a master view and a slave view
// Revision: 1.0
// ==========================================================================
interface AXI4_iface #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_mem_slave.sv
`default_nettype none
// ==========================================================================
// axi4_mem_slave: AXI4 memory responder; define AXI4_MEM_SLAVE_WRAP_EN for WRAP
// Revision: 1.0
// ==========================================================================
module axi4_mem_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input logic      i_clk,
  input logic      i_rst,
  AXI4_iface.slave s_axi
);
  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_offs  = $clog2(c_bytes);
  localparam int c_idxw  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_mem_bytes = (ADDR_WIDTH+1)'(MEM_DEPTH * c_bytes);
  localparam logic [2:0] c_size = 3'(c_offs);
`ifdef AXI4_MEM_SLAVE_WRAP_EN
  localparam logic c_wrap_en = 1'b1;
`else
  localparam logic c_wrap_en = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] bu,
                                                      input logic [7:0] ln);
    logic [ADDR_WIDTH-1:0] inc, mask;
    inc  = a + ADDR_WIDTH'(c_bytes);
    mask = ADDR_WIDTH'((32'(ln) + 32'd1) * 32'(c_bytes) - 32'd1);
    case (bu)
      2'b00:   next_addr = a;
      2'b10:   next_addr = c_wrap_en ? ((a & ~mask) | (inc & mask)) : inc;
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz,
                                    input logic [1:0] bu, input logic [7:0] ln);
    logic len_ok;
    len_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
    return ({1'b0, a} >= c_mem_bytes) || (sz != c_size) || (bu == 2'b11) ||
           ((bu == 2'b10) && !(c_wrap_en && len_ok));
  endfunction

  wstate_t               wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d;
  logic                  aw_ready, w_ready, mem_we, wr_err, wr_final;

  rstate_t               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_ready, rd_load, rd_err;

  assign aw_ready = (wstate_q == W_IDLE) && !i_rst;
  assign w_ready  = (wstate_q == W_DATA) && !i_rst;
  assign ar_ready = (rstate_q == R_IDLE) && !i_rst;

  always_comb begin
    wstate_d = wstate_q;
    awid_d   = awid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    wr_err   = 1'b0;
    wr_final = 1'b0;
    case (wstate_q)
      W_IDLE: if (s_axi.awvalid && aw_ready) begin
        awid_d   = s_axi.awid;
        waddr_d  = s_axi.awaddr;
        wlen_d   = s_axi.awlen;
        wsize_d  = s_axi.awsize;
        wburst_d = s_axi.awburst;
        wbeat_d  = 8'd0;
        werr_d   = 1'b0;
        wstate_d = W_DATA;
      end
      W_DATA: if (s_axi.wvalid && w_ready) begin
        wr_err   = beat_err(waddr_q, wsize_q, wburst_q, wlen_q);
        wr_final = (wbeat_q == wlen_q);
        mem_we   = !wr_err;
        // Burst length is set by awlen alone; a misplaced wlast only flags the response.
        if (wr_err || (s_axi.wlast != wr_final)) werr_d = 1'b1;
        wbeat_d  = wbeat_q + 8'd1;
        waddr_d  = next_addr(waddr_q, wburst_q, wlen_q);
        if (wr_final) wstate_d = W_RESP;
      end
      W_RESP: if (s_axi.bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    arid_d   = arid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rbeat_d  = rbeat_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_load  = 1'b0;
    rd_err   = 1'b0;
    case (rstate_q)
      R_IDLE: if (s_axi.arvalid && ar_ready) begin
        arid_d   = s_axi.arid;
        raddr_d  = s_axi.araddr;
        rlen_d   = s_axi.arlen;
        rsize_d  = s_axi.arsize;
        rburst_d = s_axi.arburst;
        rbeat_d  = 8'd0;
        rd_load  = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: if (s_axi.rready) begin
        if (rbeat_q == rlen_q) begin
          rstate_d = R_IDLE;
        end else begin
          rbeat_d = rbeat_q + 8'd1;
          raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
          rd_load = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    // Beat data is captured from the array before any same-edge write lands.
    if (rd_load) begin
      rd_err  = beat_err(raddr_d, rsize_d, rburst_d, rlen_d);
      rresp_d = rd_err ? 2'b10 : 2'b00;
      rdata_d = rd_err ? '0 : mem[raddr_d[c_offs +: c_idxw]];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wstate_q <= W_IDLE;
      awid_q   <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wbeat_q  <= '0;
      werr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      arid_q   <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      awid_q   <= awid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wbeat_q  <= wbeat_d;
      werr_q   <= werr_d;
      rstate_q <= rstate_d;
      arid_q   <= arid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rbeat_q  <= rbeat_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // Storage survives reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (s_axi.wstrb[b]) mem[waddr_q[c_offs +: c_idxw]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = (wstate_q == W_RESP);
  assign s_axi.bresp   = ((wstate_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;
  assign s_axi.bid     = awid_q;
  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = (rstate_q == R_DATA);
  assign s_axi.rlast   = (rstate_q == R_DATA) && (rbeat_q == rlen_q);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = arid_q;

  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};
endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_slave.sv
`default_nettype none
// ==========================================================================
// tb_axi4_mem_slave: directed bench for axi4_mem_slave (64-bit, 256 words)
// Revision: 1.0
// ==========================================================================
module tb_axi4_mem_slave;
  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];
  logic [63:0] edat [16];
  logic [1:0]  eresp [16];
  int          rstall [16];

  AXI4_iface #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .ID_WIDTH(4)) axi ();

  axi4_mem_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .ID_WIDTH(4), .MEM_DEPTH(256)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_axi (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at,
                           input int bstall, input logic [1:0] exp_bresp);
    int t;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
    axi.awburst = burst; axi.awvalid = 1'b1;
    t = 0;
    while (axi.awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("awready", axi.awready, 1'b1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wvalid = 1'b1; axi.wdata = wdat[i]; axi.wstrb = wstb[i]; axi.wlast = (i == last_at);
      t = 0;
      while (axi.wready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      chk("wready", axi.wready, 1'b1);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    t = 0;
    while (axi.bvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("bvalid", axi.bvalid, 1'b1);
    repeat (bstall) begin
      @(negedge clk);
      chk("b_hold", {axi.bvalid, axi.bresp}, {1'b1, exp_bresp});
    end
    chk("bid", axi.bid, id);
    chk("bresp", axi.bresp, exp_bresp);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    chk("bvalid_clr", axi.bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    int t;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
    axi.arburst = burst; axi.arvalid = 1'b1;
    t = 0;
    while (axi.arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("arready", axi.arready, 1'b1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    chk("rvalid_first", axi.rvalid, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      axi.rready = 1'b0;
      for (int s = 0; s < rstall[i]; s++) begin
        @(negedge clk);
        chk("r_hold", {axi.rvalid, axi.rresp, axi.rdata}, {1'b1, eresp[i], edat[i]});
      end
      chk("rdata", axi.rdata, edat[i]);
      chk("rresp", axi.rresp, eresp[i]);
      chk("rlast", axi.rlast, (i == int'(len)));
      chk("rid", axi.rid, id);
      axi.rready = 1'b1;
      @(negedge clk);
    end
    axi.rready = 1'b0;
    chk("r_done", {axi.rvalid, axi.arready}, 2'b01);
  endtask

  task automatic set_exp(input int i, input logic [63:0] d, input logic [1:0] r);
    edat[i] = d; eresp[i] = r; rstall[i] = 0;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awprot = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.wvalid = 1'b0; axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
    axi.arsize = '0; axi.arburst = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wstb[i] = 8'hFF; set_exp(i, 64'h0, 2'b00); end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", axi.awready, 1'b0);
    chk("rst_arready", axi.arready, 1'b0);
    chk("rst_wready", axi.wready, 1'b0);
    chk("rst_valids", {axi.rvalid, axi.bvalid, axi.rlast}, 3'b000);
    chk("rst_resps", {axi.rresp, axi.bresp}, 4'h0);
    chk("rst_rdata", axi.rdata, 64'h0);
    chk("rst_ids", {axi.rid, axi.bid}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {axi.awready, axi.arready}, 2'b11);

    // INCR write/read of four beats
    wdat[0] = 64'h11; wdat[1] = 64'h22; wdat[2] = 64'h33; wdat[3] = 64'h44;
    axi_write(4'h5, 16'h0010, 8'd3, 2'b01, 3'd3, 3, 2, 2'b00);
    set_exp(0, 64'h11, 2'b00); set_exp(1, 64'h22, 2'b00);
    set_exp(2, 64'h33, 2'b00); set_exp(3, 64'h44, 2'b00);
    axi_read(4'h9, 16'h0010, 8'd3, 2'b01, 3'd3);

    // Byte-lane strobes
    wdat[0] = 64'h0123_4567_89AB_CDEF;
    axi_write(4'h1, 16'h0008, 8'd0, 2'b01, 3'd3, 0, 0, 2'b00);
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(4'h2, 16'h0000, 8'd0, 2'b01, 3'd3, 0, 0, 2'b00);
    wdat[0] = 64'h0; wstb[0] = 8'h0F;
    axi_write(4'h3, 16'h0000, 8'd0, 2'b01, 3'd3, 0, 1, 2'b00);
    wstb[0] = 8'hFF;
    set_exp(0, 64'hFFFF_FFFF_0000_0000, 2'b00); set_exp(1, 64'h0123_4567_89AB_CDEF, 2'b00);
    axi_read(4'h4, 16'h0000, 8'd1, 2'b01, 3'd3);

    // Out-of-range read and write (0x800 would alias word 0)
    set_exp(0, 64'h0, 2'b10); set_exp(1, 64'h0, 2'b10);
    axi_read(4'h6, 16'h0800, 8'd1, 2'b01, 3'd3);
    wdat[0] = 64'hDEAD; wdat[1] = 64'hBEEF;
    axi_write(4'h7, 16'h0800, 8'd1, 2'b01, 3'd3, 1, 0, 2'b10);
    set_exp(0, 64'hFFFF_FFFF_0000_0000, 2'b00);
    axi_read(4'h8, 16'h0000, 8'd0, 2'b01, 3'd3);

    // wlast on beat 2 of 4, then a bad size
    wdat[0] = 64'hA; wdat[1] = 64'hB; wdat[2] = 64'hC; wdat[3] = 64'hD;
    axi_write(4'hA, 16'h0040, 8'd3, 2'b01, 3'd3, 1, 0, 2'b10);
    axi_write(4'hB, 16'h0048, 8'd0, 2'b01, 3'd2, 0, 0, 2'b10);
    set_exp(0, 64'h0, 2'b10);
    axi_read(4'hC, 16'h0010, 8'd0, 2'b01, 3'd2);

    // FIXED burst keeps hitting one word
    wdat[0] = 64'hC0; wdat[1] = 64'hC1; wdat[2] = 64'hC2;
    axi_write(4'hD, 16'h0100, 8'd2, 2'b00, 3'd3, 2, 0, 2'b00);
    set_exp(0, 64'hC2, 2'b00); set_exp(1, 64'hC2, 2'b00);
    axi_read(4'hE, 16'h0100, 8'd1, 2'b00, 3'd3);

    // WRAP read from 0x18, len 3
`ifdef AXI4_MEM_SLAVE_WRAP_EN
    set_exp(0, 64'h22, 2'b00); set_exp(1, 64'hFFFF_FFFF_0000_0000, 2'b00);
    set_exp(2, 64'h0123_4567_89AB_CDEF, 2'b00); set_exp(3, 64'h11, 2'b00);
`else
    set_exp(0, 64'h0, 2'b10); set_exp(1, 64'h0, 2'b10);
    set_exp(2, 64'h0, 2'b10); set_exp(3, 64'h0, 2'b10);
`endif
    axi_read(4'hF, 16'h0018, 8'd3, 2'b10, 3'd3);

    // Concurrent AW+AR with rready/bready backpressure
    wdat[0] = 64'hA0; wdat[1] = 64'hA1; wdat[2] = 64'hA2; wdat[3] = 64'hA3;
    set_exp(0, 64'h11, 2'b00); set_exp(1, 64'h22, 2'b00);
    set_exp(2, 64'h33, 2'b00); set_exp(3, 64'h44, 2'b00);
    rstall[1] = 2; rstall[2] = 1; rstall[3] = 3;
    fork
      axi_write(4'h3, 16'h0200, 8'd3, 2'b01, 3'd3, 3, 3, 2'b00);
      axi_read(4'h2, 16'h0010, 8'd3, 2'b01, 3'd3);
    join
    set_exp(0, 64'hA0, 2'b00); set_exp(1, 64'hA1, 2'b00);
    set_exp(2, 64'hA2, 2'b00); set_exp(3, 64'hA3, 2'b00);
    for (int i = 0; i < 4; i++) rstall[i] = 1;
    axi_read(4'h1, 16'h0200, 8'd3, 2'b01, 3'd3);

    // INCR address rolls over 0xFFF8 -> 0x0000 (first beat out of range)
    wdat[0] = 64'h0BAD; wdat[1] = 64'h600D;
    axi_write(4'h4, 16'hFFF8, 8'd1, 2'b01, 3'd3, 1, 0, 2'b10);
    set_exp(0, 64'h0, 2'b10); set_exp(1, 64'h600D, 2'b00);
    axi_read(4'h5, 16'hFFF8, 8'd1, 2'b01, 3'd3);

    // Reset in the middle of both bursts
    axi.awid = 4'h3; axi.awaddr = 16'h0300; axi.awlen = 8'd3; axi.awsize = 3'd3;
    axi.awburst = 2'b01; axi.awvalid = 1'b1;
    axi.arid = 4'h7; axi.araddr = 16'h0010; axi.arlen = 8'd3; axi.arsize = 3'd3;
    axi.arburst = 2'b01; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    chk("both_accept", {axi.wready, axi.rvalid}, 2'b11);
    axi.wvalid = 1'b1; axi.wdata = 64'h77; axi.wstrb = 8'hFF; axi.wlast = 1'b0; axi.rready = 1'b1;
    @(negedge clk);
    chk("mid_burst", {axi.wready, axi.rvalid, axi.rdata}, {2'b11, 64'h22});
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {axi.awready, axi.arready, axi.wready, axi.rvalid, axi.bvalid, axi.rlast,
                        axi.rresp, axi.bresp, axi.rid, axi.bid}, 18'h0);
    chk("rst_mid_rdata", axi.rdata, 64'h0);
    axi.wvalid = 1'b0; axi.rready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort", {axi.awready, axi.arready, axi.bvalid, axi.rvalid}, 4'b1100);
    repeat (3) @(negedge clk);
    chk("no_resp", {axi.bvalid, axi.rvalid}, 2'b00);
    set_exp(0, 64'hC2, 2'b00);
    axi_read(4'h0, 16'h0100, 8'd0, 2'b01, 3'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire
